cycle_sequencer: RTL and testbench



---
 rtl/cycle_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_cycle_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// T-cycle command decoder for the 2A03 instruction controller: reset/interrupt entry, RDY stalls.
// Define CYCLE_SEQ_JAM_EN to make the NMOS JAM opcodes halt the core; otherwise they run as 2-cycle NOPs.
module cycle_sequencer #(
   parameter int MAX_CYCLE = 6
) (
   input  logic       sys_clock,
   input  logic       rst_n,
   input  logic       clk_phase_1,
   input  logic       clk_phase_2,
   input  logic [7:0] IR_register,
   input  logic [2:0] cycle,
   input  logic       page_cross,
   input  logic       branch_taken,
   input  logic       nmi_pending,
   input  logic       irq_pending,
   input  logic       rdy,
   output logic       increment_cycle_counter,
   output logic       reset_cycle_counter,
   output logic       skip_cycle_counter,
   output logic       interrupt_flag,
   output logic [1:0] vector_sel,
   output logic       sync,
   output logic       halted
);

   localparam logic [2:0] MAX_C    = 3'(MAX_CYCLE);
   localparam logic [2:0] SEQ_LAST = 3'd6;

   typedef enum logic [1:0] {RESET_SEQ, RUN, INT_SEQ, JAM} state_t;

   typedef struct packed {
      logic [2:0] last;
      logic       fixup;
      logic [2:0] fix_at;
      logic       branch;
      logic [7:0] wr_mask;
   } op_info_t;

   // Timing is derived from the aaa/bbb/cc opcode fields rather than a 256-entry table.
   function automatic op_info_t decode_op(input logic [7:0] op);
      op_info_t   d;
      logic [2:0] aaa;
      logic [2:0] bbb;
      logic       store;
      logic       rmw;
      aaa    = op[7:5];
      bbb    = op[4:2];
      d      = '0;
      d.last = 3'd1;
      store  = 1'b0;
      rmw    = 1'b0;
      if (op[0]) begin
         store = (aaa == 3'b100) && (bbb != 3'b010);
         case (bbb)
            3'b000:  d.last = 3'd5;
            3'b001:  d.last = 3'd2;
            3'b010:  d.last = 3'd1;
            3'b011:  d.last = 3'd3;
            3'b100:  begin d.last = 3'd5; d.fixup = !store; d.fix_at = 3'd3; end
            3'b101:  d.last = 3'd3;
            default: begin d.last = 3'd4; d.fixup = !store; d.fix_at = 3'd2; end
         endcase
      end else if (op[1]) begin
         store = (aaa == 3'b100);
         rmw   = (aaa != 3'b100) && (aaa != 3'b101);
         case (bbb)
            3'b001:         d.last = rmw ? 3'd4 : 3'd2;
            3'b011, 3'b101: d.last = rmw ? 3'd5 : 3'd3;
            3'b111: begin
               d.last   = rmw ? 3'd6 : 3'd4;
               d.fixup  = !rmw && !store;
               d.fix_at = 3'd2;
            end
            default: begin store = 1'b0; rmw = 1'b0; end
         endcase
      end else begin
         store = (aaa == 3'b100);
         case (bbb)
            3'b000: begin
               store = 1'b0;
               case (aaa)
                  3'b000:         begin d.last = 3'd6; d.wr_mask = 8'b0001_1100; end
                  3'b001:         begin d.last = 3'd5; d.wr_mask = 8'b0001_1000; end
                  3'b010, 3'b011: d.last = 3'd5;
                  default:        d.last = 3'd1;
               endcase
            end
            3'b001: d.last = 3'd2;
            3'b010: begin
               store = 1'b0;
               case (aaa)
                  3'b000, 3'b010: begin d.last = 3'd2; d.wr_mask = 8'b0000_0100; end
                  3'b001, 3'b011: d.last = 3'd3;
                  default:        d.last = 3'd1;
               endcase
            end
            3'b011: begin
               if (aaa == 3'b010)      d.last = 3'd2;
               else if (aaa == 3'b011) d.last = 3'd4;
               else                    d.last = 3'd3;
            end
            3'b100:  begin store = 1'b0; d.branch = 1'b1; d.last = 3'd3; end
            3'b101:  d.last = 3'd3;
            3'b110:  begin store = 1'b0; d.last = 3'd1; end
            default: begin d.last = 3'd4; d.fixup = !store; d.fix_at = 3'd2; end
         endcase
      end
      if (store) d.wr_mask = d.wr_mask | (8'b1 << d.last);
      if (rmw)   d.wr_mask = d.wr_mask | (8'b1 << d.last) | (8'b1 << (d.last - 3'd1));
      return d;
   endfunction

   state_t   state_reg;
   op_info_t op_info;
   logic     end_of_op;
   logic     skip_hit;
   logic     write_cycle;
   logic     inc_reg;
   logic     rst_cmd_reg;
   logic     skip_reg;
   logic     int_flag_reg;
   logic [1:0] vector_reg;

   assign op_info   = decode_op(IR_register);
   assign end_of_op = (cycle == op_info.last)
                   || (op_info.branch && (cycle == 3'd1) && !branch_taken)
                   || (op_info.branch && (cycle == 3'd2) && !page_cross);
   assign skip_hit  = op_info.fixup && (cycle == op_info.fix_at) && !page_cross;

   // RDY cannot stall a bus write, so write cycles keep advancing.
   always_comb begin
      write_cycle = 1'b0;
      case (state_reg)
         RUN:     write_cycle = op_info.wr_mask[cycle];
         INT_SEQ: write_cycle = (cycle >= 3'd2) && (cycle <= 3'd4);
         default: write_cycle = 1'b0;
      endcase
   end

`ifdef CYCLE_SEQ_JAM_EN
   logic halted_reg;
   logic jam_op;
   assign jam_op = (IR_register[1:0] == 2'b10)
                && ((IR_register[4:2] == 3'b100) || ((IR_register[4:2] == 3'b000) && !IR_register[7]));
   assign halted = halted_reg;
`else
   assign halted = 1'b0;
`endif

   always_ff @(posedge sys_clock or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= RESET_SEQ;
         inc_reg      <= 1'b0;
         rst_cmd_reg  <= 1'b1;
         skip_reg     <= 1'b0;
         int_flag_reg <= 1'b1;
         vector_reg   <= 2'd2;
`ifdef CYCLE_SEQ_JAM_EN
         halted_reg   <= 1'b0;
`endif
      end else if (clk_phase_2 && (rdy || write_cycle)) begin
         inc_reg     <= 1'b0;
         rst_cmd_reg <= 1'b0;
         skip_reg    <= 1'b0;
         case (state_reg)
            RESET_SEQ, INT_SEQ: begin
               if (cycle >= SEQ_LAST) begin
                  rst_cmd_reg  <= 1'b1;
                  int_flag_reg <= 1'b0;
                  state_reg    <= RUN;
               end else begin
                  inc_reg <= 1'b1;
               end
            end
            RUN: begin
               if (cycle > MAX_C) begin
                  rst_cmd_reg <= 1'b1;
               end
`ifdef CYCLE_SEQ_JAM_EN
               else if (jam_op && (cycle == 3'd1)) begin
                  state_reg  <= JAM;
                  halted_reg <= 1'b1;
               end
`endif
               else if (end_of_op) begin
                  rst_cmd_reg <= 1'b1;
                  if (nmi_pending || irq_pending) begin
                     int_flag_reg <= 1'b1;
                     vector_reg   <= nmi_pending ? 2'd1 : 2'd0;
                     state_reg    <= INT_SEQ;
                  end
               end else if (skip_hit) begin
                  skip_reg <= 1'b1;
               end else begin
                  inc_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign increment_cycle_counter = inc_reg;
   assign reset_cycle_counter     = rst_cmd_reg;
   assign skip_cycle_counter      = skip_reg;
   assign interrupt_flag          = int_flag_reg;
   assign vector_sel              = vector_reg;
   assign sync                    = (cycle == 3'd0) && (state_reg == RUN);

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: models the instruction_controller counter and checks command traces.
// Trace letters: I=increment, R=reset, S=skip, -=none, X=several; prefix + = T0 in RUN, ~ = otherwise.
module tb_cycle_sequencer;
   logic       sys_clock = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] ph = 2'd0;
   logic       clk_phase_1;
   logic       clk_phase_2;
   logic [7:0] IR_register = 8'hEA;
   logic [2:0] cycle = 3'd0;
   logic       page_cross = 1'b0;
   logic       branch_taken = 1'b0;
   logic       nmi_pending = 1'b0;
   logic       irq_pending = 1'b0;
   logic       rdy = 1'b1;
   logic       increment_cycle_counter;
   logic       reset_cycle_counter;
   logic       skip_cycle_counter;
   logic       interrupt_flag;
   logic [1:0] vector_sel;
   logic       sync;
   logic       halted;

   int n_checks = 0;
   int n_errors = 0;

   cycle_sequencer #(.MAX_CYCLE(6)) dut (
      .sys_clock               (sys_clock),
      .rst_n                   (rst_n),
      .clk_phase_1             (clk_phase_1),
      .clk_phase_2             (clk_phase_2),
      .IR_register             (IR_register),
      .cycle                   (cycle),
      .page_cross              (page_cross),
      .branch_taken            (branch_taken),
      .nmi_pending             (nmi_pending),
      .irq_pending             (irq_pending),
      .rdy                     (rdy),
      .increment_cycle_counter (increment_cycle_counter),
      .reset_cycle_counter     (reset_cycle_counter),
      .skip_cycle_counter      (skip_cycle_counter),
      .interrupt_flag          (interrupt_flag),
      .vector_sel              (vector_sel),
      .sync                    (sync),
      .halted                  (halted)
   );

   always #5 sys_clock = ~sys_clock;

   assign clk_phase_1 = (ph == 2'd0);
   assign clk_phase_2 = (ph == 2'd2);

   // Controller model: consumes the command on phi1, frozen while RDY is low.
   always @(posedge sys_clock) begin
      ph <= ph + 2'd1;
      if (clk_phase_1 && rdy) begin
         if (reset_cycle_counter)         cycle <= 3'd0;
         else if (skip_cycle_counter)     cycle <= cycle + 3'd2;
         else if (increment_cycle_counter) cycle <= cycle + 3'd1;
      end
   end

   typedef struct {
      string      name;
      logic [7:0] op;
      logic       pc;
      logic       bt;
      string      exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input string nm, input logic [7:0] op, input logic pc,
                          input logic bt, input string exp);
      vec_t v;
      v.name = nm;
      v.op   = op;
      v.pc   = pc;
      v.bt   = bt;
      v.exp  = exp;
      vecs.push_back(v);
   endtask

   task automatic check_str(input string nm, input string act, input string exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %s, expected %s", nm, act, exp);
      end else begin
         $display("ok   %s: %s", nm, act);
      end
   endtask

   task automatic check_val(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", nm, act);
      end
   endtask

   function automatic string cmd_letter();
      case ({increment_cycle_counter, reset_cycle_counter, skip_cycle_counter})
         3'b100:  return "I";
         3'b010:  return "R";
         3'b001:  return "S";
         3'b000:  return "-";
         default: return "X";
      endcase
   endfunction

   // Advance to #1 after the sys_clock edge that leaves ph at target (3: just after phi2, 1: just after phi1).
   task automatic wait_ph(input logic [1:0] target);
      for (int i = 0; i < 8; i++) begin
         @(posedge sys_clock);
         #1;
         if (ph == target) return;
      end
      n_checks++;
      n_errors++;
      $display("FAIL wait_ph: phase %0d never reached", target);
   endtask

   task automatic collect(output string tr, input int max_len, input logic stop_at_r);
      tr = "";
      for (int i = 0; i < max_len; i++) begin
         wait_ph(2'd3);
         tr = {tr, cmd_letter()};
         if (stop_at_r && reset_cycle_counter) return;
      end
   endtask

   // Starts just after the phi2 that ended the previous sequence; runs one full instruction.
   task automatic run_op(input logic [7:0] op, input logic pc, input logic bt,
                         input logic nm, input logic iq, output string tr);
      string body;
      wait_ph(2'd1);
      IR_register  = op;
      page_cross   = pc;
      branch_taken = bt;
      nmi_pending  = nm;
      irq_pending  = iq;
      if (sync && !interrupt_flag) tr = "+";
      else                         tr = "~";
      collect(body, 12, 1'b1);
      tr = {tr, body};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      string tr;
      string tr2;

      add_vec("LDA abs,X no cross",   8'hBD, 1'b0, 1'b0, "+IISR");
      add_vec("LDA abs,X cross",      8'hBD, 1'b1, 1'b0, "+IIIIR");
      add_vec("BNE not taken",        8'hD0, 1'b0, 1'b0, "+IR");
      add_vec("BNE taken same page",  8'hD0, 1'b0, 1'b1, "+IIR");
      add_vec("BNE taken cross",      8'hD0, 1'b1, 1'b1, "+IIIR");
      add_vec("NOP",                  8'hEA, 1'b0, 1'b0, "+IR");
      add_vec("LDA zp",               8'hA5, 1'b0, 1'b0, "+IIR");
      add_vec("LDA abs",              8'hAD, 1'b0, 1'b0, "+IIIR");
      add_vec("LDA (ind),Y no cross", 8'hB1, 1'b0, 1'b0, "+IIISR");
      add_vec("LDA (ind),Y cross",    8'hB1, 1'b1, 1'b0, "+IIIIIR");
      add_vec("LDA (ind,X)",          8'hA1, 1'b0, 1'b0, "+IIIIIR");
      add_vec("STA abs,X no cross",   8'h9D, 1'b0, 1'b0, "+IIIIR");
      add_vec("STA (ind),Y",          8'h91, 1'b0, 1'b0, "+IIIIIR");
      add_vec("INC abs,X",            8'hFE, 1'b0, 1'b0, "+IIIIIIR");
      add_vec("ASL zp",               8'h06, 1'b0, 1'b0, "+IIIIR");
      add_vec("LDX abs,Y no cross",   8'hBE, 1'b0, 1'b0, "+IISR");
      add_vec("LDX zp,Y",             8'hB6, 1'b0, 1'b0, "+IIIR");
      add_vec("PHA",                  8'h48, 1'b0, 1'b0, "+IIR");
      add_vec("PLA",                  8'h68, 1'b0, 1'b0, "+IIIR");
      add_vec("JMP abs",              8'h4C, 1'b0, 1'b0, "+IIR");
      add_vec("JMP ind",              8'h6C, 1'b0, 1'b0, "+IIIIR");
      add_vec("JSR",                  8'h20, 1'b0, 1'b0, "+IIIIIR");
      add_vec("RTS",                  8'h60, 1'b0, 1'b0, "+IIIIIR");
      add_vec("BRK",                  8'h00, 1'b0, 1'b0, "+IIIIIIR");
`ifndef CYCLE_SEQ_JAM_EN
      add_vec("0x02 as NOP",          8'h02, 1'b0, 1'b0, "+IR");
`endif

      // Reset held for 3 clocks
      repeat (3) @(posedge sys_clock);
      #1;
      check_val("reset strobes {inc,rst,skip}",
                {5'd0, increment_cycle_counter, reset_cycle_counter, skip_cycle_counter}, 8'b010);
      check_val("reset vector_sel", {6'd0, vector_sel}, 8'd2);
      check_val("reset interrupt_flag", {7'd0, interrupt_flag}, 8'd1);
      check_val("reset sync/halted", {6'd0, sync, halted}, 8'd0);
      wait_ph(2'd3);
      rst_n = 1'b1;
      run_op(8'hEA, 1'b0, 1'b0, 1'b0, 1'b0, tr);
      check_str("RESET_SEQ", tr, "~IIIIIIR");

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].pc, vecs[i].bt, 1'b0, 1'b0, tr);
         check_str(vecs[i].name, tr, vecs[i].exp);
      end

      // IRQ and NMI together at the end of a NOP: NMI wins
      run_op(8'hEA, 1'b0, 1'b0, 1'b1, 1'b1, tr);
      check_str("NOP with NMI+IRQ", tr, "+IR");
      check_val("NMI+IRQ flag/vector", {5'd0, interrupt_flag, vector_sel}, 8'b101);
      run_op(8'hEA, 1'b0, 1'b0, 1'b0, 1'b0, tr);
      check_str("INT_SEQ after NMI", tr, "~IIIIIIR");
      check_val("flag cleared after INT_SEQ", {7'd0, interrupt_flag}, 8'd0);

      // IRQ alone, then an NMI raised during INT_SEQ is deferred to the next instruction end
      run_op(8'hEA, 1'b0, 1'b0, 1'b0, 1'b1, tr);
      check_str("NOP with IRQ", tr, "+IR");
      check_val("IRQ flag/vector", {5'd0, interrupt_flag, vector_sel}, 8'b100);
      run_op(8'hEA, 1'b0, 1'b0, 1'b1, 1'b0, tr);
      check_str("INT_SEQ ignores NMI", tr, "~IIIIIIR");
      run_op(8'hEA, 1'b0, 1'b0, 1'b1, 1'b0, tr);
      check_str("deferred NMI taken", tr, "+IR");
      check_val("deferred NMI flag/vector", {5'd0, interrupt_flag, vector_sel}, 8'b101);
      run_op(8'hEA, 1'b0, 1'b0, 1'b0, 1'b0, tr);
      check_str("INT_SEQ deferred NMI", tr, "~IIIIIIR");

      // RDY low for 5 cycles at T2 of LDA abs
      wait_ph(2'd1);
      IR_register = 8'hAD;
      collect(tr, 2, 1'b0);
      wait_ph(2'd1);
      rdy = 1'b0;
      collect(tr2, 5, 1'b0);
      check_str("RDY stall commands", tr2, "IIIII");
      wait_ph(2'd1);
      check_val("RDY stall cycle held", {5'd0, cycle}, 8'd2);
      rdy = 1'b1;
      collect(tr2, 12, 1'b1);
      check_str("RDY resumed LDA abs", {tr, tr2}, "IIIR");

      // Asynchronous reset in the middle of LDA abs,X
      wait_ph(2'd1);
      IR_register = 8'hBD;
      page_cross  = 1'b1;
      collect(tr, 2, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("async reset strobes {inc,rst,skip}",
                {5'd0, increment_cycle_counter, reset_cycle_counter, skip_cycle_counter}, 8'b010);
      check_val("async reset flag/vector", {5'd0, interrupt_flag, vector_sel}, 8'b110);
      wait_ph(2'd3);
      rst_n = 1'b1;
      run_op(8'hEA, 1'b0, 1'b0, 1'b0, 1'b0, tr);
      check_str("RESET_SEQ after abort", tr, "~IIIIIIR");

`ifdef CYCLE_SEQ_JAM_EN
      // JAM: halts from T1, ignores IRQ, only rst_n recovers
      wait_ph(2'd1);
      IR_register = 8'h02;
      irq_pending = 1'b1;
      collect(tr, 2, 1'b0);
      check_str("JAM entry commands", tr, "I-");
      check_val("JAM halted", {7'd0, halted}, 8'd1);
      collect(tr, 4, 1'b0);
      check_str("JAM no strobes", tr, "----");
      wait_ph(2'd1);
      check_val("JAM cycle/sync", {4'd0, cycle, sync}, 8'b0010);
      rst_n = 1'b0;
      #1;
      check_val("JAM cleared by reset", {6'd0, halted, reset_cycle_counter}, 8'b01);
      wait_ph(2'd3);
      rst_n = 1'b1;
      irq_pending = 1'b0;
      run_op(8'hEA, 1'b0, 1'b0, 1'b0, 1'b0, tr);
      check_str("RESET_SEQ after JAM", tr, "~IIIIIIR");
`else
      check_val("halted tied low", {7'd0, halted}, 8'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
